pp_pipeline_accel_mul_arbiter: RTL and testbench
================================================

# pp_pipeline_accel_mul_arbiter

Round-robin arbiter and sequencer that shares one pipelined 16x16 unsigned multiplier among NUM_REQ requesters in the pp_pipeline_accel datapath. Each accepted operand pair is tagged with its requester ID. The tag travels through a valid/ID shift pipe kept in lockstep with the multiplier's stages. Products return on a single tagged result port with backpressure, which stalls the whole multiplier pipe through its clock enable.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, ceil(log2(NUM_REQ))
- DIN_W, 16, operand width (unsigned)
- DOUT_W, 32, product width, 2*DIN_W
- MUL_LATENCY, 4, cycles from issue to product: 1 arbiter operand register + 3 multiplier-internal stages
- CNT_W, 3, width of inflight, ceil(log2(MUL_LATENCY+1))

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_a  in  NUM_REQ*DIN_W  packed operand A, requester i at [i*DIN_W +: DIN_W]
- req_b  in  NUM_REQ*DIN_W  packed operand B, same packing
- mul_ce  out  1  clock enable to the multiplier
- mul_din0  out  DIN_W  registered operand A to the multiplier
- mul_din1  out  DIN_W  registered operand B to the multiplier
- mul_dout  in  DOUT_W  multiplier product
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_id  out  ID_W  requester ID of the result
- out_p  out  DOUT_W  product, wired from mul_dout
- inflight  out  CNT_W  number of valid tags in the pipe
- busy  out  1  inflight != 0

## Operation
- stall = out_valid & ~out_ready. mul_ce = ~stall & ~reset.
- Arbitration is combinational:
  - Priority starts at (last_ptr+1) mod NUM_REQ and searches upward with wrap.
  - The first i with req_valid[i] wins.
  - req_ready[i] = win[i] & mul_ce.
  - At most one bit of req_ready is high.
- Issue = |(req_valid & req_ready). On issue at a clock edge:
  - mul_din0/mul_din1 load the winner's req_a/req_b.
  - Tag stage 0 loads {1, winner ID}.
  - last_ptr loads the winner ID.
- mul_ce=1 with no issue: tag stage 0 loads valid=0, ID=0 (bubble). mul_din0/1 hold their values.
- mul_ce=0: the operand registers, all tag stages and last_ptr hold. The multiplier holds through its ce.
- Tag pipe has MUL_LATENCY stages and shifts only when mul_ce=1.
  - out_valid and out_id come from the last stage.
  - Bubbles are not compressed.
- inflight = popcount of tag valid bits.
- A requester must hold req_valid/req_a/req_b stable until req_ready. The arbiter does not check this.
- Arithmetic is unsigned: out_p = req_a * req_b, exact in DOUT_W bits, no overflow.
- Result order equals issue order.

## Timing
- Reset (asynchronous assert; deassert synchronized externally):
  - All tag valids = 0, IDs = 0.
  - last_ptr = NUM_REQ-1, so requester 0 has first priority.
  - mul_din0 = mul_din1 = 0.
  - out_valid = 0, out_id = 0, inflight = 0, busy = 0.
  - req_ready = 0 and mul_ce = 0 while reset is high.
  - out_p mirrors mul_dout and is don't-care while out_valid = 0.
- Latency: transfer in cycle t gives out_valid in cycle t+MUL_LATENCY when there is no stall. Each stall cycle adds one.
- Throughput is one issue per cycle while unstalled.
- A result transfers when out_valid & out_ready.
  - With out_ready=1 the pipe advances every cycle.
  - A simultaneous transfer and new issue is legal.
- Reset mid-operation discards every in-flight tag. Stale mul_dout is never flagged valid.
- A requester whose req_valid drops while ungranted is simply skipped, with no lock-in.

## Test plan
- Single request: requester 2 sends a=3, b=5 in cycle 10 -> out_valid in cycle 14, out_id=2, out_p=15. inflight reads 1 during cycles 11-14.
- All four requesters hold req_valid for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3. Results return in that order with correct products.
- Back-to-back: requester 1 streams 6 pairs (i, i+1) -> 6 consecutive out_valid cycles, products 0,2,6,12,20,30.
- Backpressure: out_ready=0 for 5 cycles while 3 results are in flight -> mul_ce=0, req_ready=0, out_valid/out_id/out_p held. After release, all 3 results arrive in order with none lost or duplicated.
- Extremes: a=b=0xFFFF -> out_p=0xFFFE0001. a=0, b=0xFFFF -> 0.
- Reset pulse with 3 in flight -> out_valid=0 and inflight=0 immediately. No stale result appears. The first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/pp_pipeline_accel_mul_arbiter.sv
// Round-robin front end that shares one pipelined unsigned multiplier among NUM_REQ
// requesters, tagging each product with its requester ID on a single backpressured result port.
module pp_pipeline_accel_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DIN_W       = 16,
  parameter int DOUT_W      = 32,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DIN_W-1:0] req_a,
  input  logic [NUM_REQ*DIN_W-1:0] req_b,
  output logic                     mul_ce,
  output logic [DIN_W-1:0]         mul_din0,
  output logic [DIN_W-1:0]         mul_din1,
  input  logic [DOUT_W-1:0]        mul_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ID_W-1:0]          out_id,
  output logic [DOUT_W-1:0]        out_p,
  output logic [CNT_W-1:0]         inflight,
  output logic                     busy
);

  // Scans downward from the lowest priority so the highest-priority hit is written last.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] pick;
    int            idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (int'(ptr) + k) % NUM_REQ;
      pick = valid[ID_W'(idx)] ? {1'b1, ID_W'(idx)} : pick;
    end
    return pick;
  endfunction

  logic [MUL_LATENCY-1:0] tag_valid_r;
  logic [ID_W-1:0]        tag_id_r [MUL_LATENCY];
  logic [ID_W-1:0]        last_ptr_r;
  logic [DIN_W-1:0]       din0_r;
  logic [DIN_W-1:0]       din1_r;
  logic [CNT_W-1:0]       inflight_r;
  logic                   busy_r;

  logic                   stall_s;
  logic                   ce_s;
  logic                   pick_found_s;
  logic [ID_W-1:0]        pick_id_s;
  logic [NUM_REQ-1:0]     win_s;
  logic [NUM_REQ-1:0]     req_ready_s;
  logic                   issue_s;
  logic [DIN_W-1:0]       sel_a_s;
  logic [DIN_W-1:0]       sel_b_s;
  logic [CNT_W-1:0]       inflight_next_s;

  // Arbitration, stall/enable generation, operand select and occupancy update.
  always_comb begin
    stall_s                   = tag_valid_r[MUL_LATENCY-1] & ~out_ready;
    ce_s                      = ~stall_s & ~reset;
    {pick_found_s, pick_id_s} = rr_pick(req_valid, last_ptr_r);
    win_s                     = '0;
    if (pick_found_s) begin
      win_s[pick_id_s] = 1'b1;
    end else begin
      win_s = '0;
    end
    req_ready_s = win_s & {NUM_REQ{ce_s}};
    issue_s     = |(req_valid & req_ready_s);
    sel_a_s     = DIN_W'(req_a >> (int'(pick_id_s) * DIN_W));
    sel_b_s     = DIN_W'(req_b >> (int'(pick_id_s) * DIN_W));
    // Occupancy tracks the tag popcount: one enters on issue, one leaves from the last stage.
    inflight_next_s = inflight_r;
    if (ce_s) begin
      inflight_next_s = inflight_r + CNT_W'(issue_s) - CNT_W'(tag_valid_r[MUL_LATENCY-1]);
    end else begin
      inflight_next_s = inflight_r;
    end
  end

  // Operand registers, tag shift pipe and round-robin pointer; everything freezes while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid_r <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_id_r[i] <= '0;
      end
      last_ptr_r <= ID_W'(NUM_REQ - 1);
      din0_r     <= '0;
      din1_r     <= '0;
      inflight_r <= '0;
      busy_r     <= 1'b0;
    end else if (ce_s) begin
      tag_valid_r <= {tag_valid_r[MUL_LATENCY-2:0], issue_s};
      tag_id_r[0] <= issue_s ? pick_id_s : '0;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
      inflight_r <= inflight_next_s;
      busy_r     <= (inflight_next_s != '0);
      if (issue_s) begin
        last_ptr_r <= pick_id_s;
        din0_r     <= sel_a_s;
        din1_r     <= sel_b_s;
      end
    end
  end

  assign req_ready = req_ready_s;
  assign mul_ce    = ce_s;
  assign mul_din0  = din0_r;
  assign mul_din1  = din1_r;
  assign out_valid = tag_valid_r[MUL_LATENCY-1];
  assign out_id    = tag_id_r[MUL_LATENCY-1];
  assign out_p     = mul_dout;
  assign inflight  = inflight_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_pp_pipeline_accel_mul_arbiter.sv
// Directed bench: a 3-stage clock-enabled multiplier model behind the arbiter, checked cycle by cycle.
module tb_pp_pipeline_accel_mul_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        mul_ce;
  logic [15:0] mul_din0;
  logic [15:0] mul_din1;
  logic [31:0] mul_dout;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [31:0] out_p;
  logic [2:0]  inflight;
  logic        busy;

  logic [31:0] p1_r, p2_r, p3_r;
  int checks = 0;
  int errors = 0;

  pp_pipeline_accel_mul_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_p(out_p),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier with three internal stages, held by its clock enable; never reset.
  always @(posedge clk) begin
    if (mul_ce) begin
      p1_r <= 32'(mul_din0) * 32'(mul_din1);
      p2_r <= p1_r;
      p3_r <= p2_r;
    end
  end
  assign mul_dout = p3_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    req_a     = 64'h0;
    req_b     = 64'h0;
    out_ready = 1'b1;
    next();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_ce", 32'(mul_ce), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_id", 32'(out_id), 32'h0);
    check("rst_inflight", 32'(inflight), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_din0", 32'(mul_din0), 32'h0);
    check("rst_din1", 32'(mul_din1), 32'h0);
    req_valid = 4'h0;
    reset     = 1'b0;
    next();
    next();

    // Single request from requester 2.
    set_req(2, 16'd3, 16'd5);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    check("single_ce", 32'(mul_ce), 32'h1);
    next();
    req_valid = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("single_inflight", 32'(inflight), (k <= 4) ? 32'd1 : 32'd0);
      check("single_busy", 32'(busy), (k <= 4) ? 32'd1 : 32'd0);
      check("single_valid", 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) begin
        check("single_id", 32'(out_id), 32'd2);
        check("single_p", out_p, 32'd15);
      end
      next();
    end

    // Round robin with all four requesters asserted after a fresh reset.
    reset = 1'b1;
    next();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 16'(i + 2), 16'(10 * (i + 1)));
    for (int j = 0; j < 14; j++) begin
      req_valid = (j < 8) ? 4'hF : 4'h0;
      #1;
      if (j < 8) check("rr_grant", 32'(req_ready), 32'(1 << (j % 4)));
      if (j == 5) check("rr_inflight", 32'(inflight), 32'd4);
      if (j >= 4 && j < 12) begin
        check("rr_valid", 32'(out_valid), 32'd1);
        check("rr_id", 32'(out_id), 32'((j - 4) % 4));
        check("rr_p", out_p, 32'((((j - 4) % 4) + 2) * 10 * (((j - 4) % 4) + 1)));
      end
      if (j >= 12) check("rr_drain", 32'(out_valid), 32'd0);
      next();
    end

    // Back-to-back stream from requester 1.
    for (int j = 0; j < 11; j++) begin
      if (j < 6) begin
        req_valid = 4'b0010;
        set_req(1, 16'(j), 16'(j + 1));
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (j < 6) check("b2b_ready", 32'(req_ready), 32'h2);
      if (j >= 4 && j < 10) begin
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_id", 32'(out_id), 32'd1);
        check("b2b_p", out_p, 32'((j - 4) * (j - 3)));
      end
      if (j == 10) check("b2b_end", 32'(out_valid), 32'd0);
      next();
    end

    // Backpressure: three results in flight, consumer stalls for five cycles.
    for (int j = 0; j < 14; j++) begin
      if (j < 3) begin
        req_valid = 4'b0001;
        set_req(0, 16'(7 + 2 * j), 16'(8 + 2 * j));
      end else if (j >= 4 && j <= 9) begin
        req_valid = 4'b1000;
        set_req(3, 16'd2, 16'd3);
      end else begin
        req_valid = 4'b0000;
      end
      out_ready = !(j >= 4 && j <= 8);
      #1;
      if (j < 3) check("bp_issue", 32'(req_ready), 32'h1);
      if (j >= 4 && j <= 8) begin
        check("bp_ce", 32'(mul_ce), 32'd0);
        check("bp_ready", 32'(req_ready), 32'h0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_id", 32'(out_id), 32'd0);
        check("bp_p", out_p, 32'd56);
      end
      if (j == 6) check("bp_inflight", 32'(inflight), 32'd3);
      if (j == 9) begin
        check("bp_rel_ready", 32'(req_ready), 32'h8);
        check("bp_rel_p0", out_p, 32'd56);
      end
      if (j == 10) check("bp_p1", out_p, 32'd90);
      if (j == 11) check("bp_p2", out_p, 32'd132);
      if (j >= 10 && j <= 11) check("bp_v12", 32'(out_valid), 32'd1);
      if (j == 12) check("bp_bubble", 32'(out_valid), 32'd0);
      if (j == 13) begin
        check("bp_v3", 32'(out_valid), 32'd1);
        check("bp_id3", 32'(out_id), 32'd3);
        check("bp_p3", out_p, 32'd6);
      end
      next();
    end
    out_ready = 1'b1;

    // Operand extremes.
    for (int j = 0; j < 7; j++) begin
      if (j == 0) begin
        req_valid = 4'b0100;
        set_req(2, 16'hFFFF, 16'hFFFF);
      end else if (j == 1) begin
        req_valid = 4'b0100;
        set_req(2, 16'h0000, 16'hFFFF);
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (j < 2) check("ext_ready", 32'(req_ready), 32'h4);
      if (j == 4 || j == 5) begin
        check("ext_valid", 32'(out_valid), 32'd1);
        check("ext_id", 32'(out_id), 32'd2);
      end
      if (j == 4) check("ext_max", out_p, 32'hFFFE0001);
      if (j == 5) check("ext_zero", out_p, 32'h0);
      next();
    end

    // Reset pulse with three products in flight.
    for (int j = 0; j < 4; j++) begin
      if (j < 3) begin
        req_valid = 4'b0010;
        set_req(1, 16'd5, 16'd5);
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (j < 3) check("rp_ready", 32'(req_ready), 32'h2);
      if (j == 3) check("rp_inflight", 32'(inflight), 32'd3);
      if (j < 3) next();
    end
    reset = 1'b1;
    #1;
    check("rp_valid", 32'(out_valid), 32'd0);
    check("rp_inflight0", 32'(inflight), 32'd0);
    check("rp_busy", 32'(busy), 32'd0);
    check("rp_ce", 32'(mul_ce), 32'd0);
    req_valid = 4'hF;
    #1;
    check("rp_ready0", 32'(req_ready), 32'h0);
    next();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 16'(6 + i), 16'(7 + i));
    #1;
    check("rp_first_grant", 32'(req_ready), 32'h1);
    check("rp_stale0", 32'(out_valid), 32'd0);
    next();
    req_valid = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("rp_stale", 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) begin
        check("rp_id", 32'(out_id), 32'd0);
        check("rp_p", out_p, 32'd42);
      end
      next();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
